// File: rtl/regdst_pkg.sv
// Shared encodings and default sizes for the write-back destination tracker.
package regdst_pkg;

  typedef enum logic [1:0] {
    DST_RT   = 2'b00,
    DST_RD   = 2'b01,
    DST_LINK = 2'b10,
    DST_RSV  = 2'b11
  } dst_sel_e;

  localparam int REG_W_DEF    = 5;
  localparam int LINK_REG_DEF = 31;

endpackage

// File: rtl/regdst_stage.sv
// One in-flight slot of the destination tracker: holds {dst, vld} with load, bubble and hold.
module regdst_stage #(
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             bubble,
  input  logic [REG_W-1:0] d_dst,
  input  logic             d_vld,
  output logic [REG_W-1:0] q_dst,
  output logic             q_vld
);

  // Bubble beats load; neither asserted means the slot holds.
  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      q_dst <= '0;
      q_vld <= 1'b0;
    end else if (load) begin
      q_dst <= d_dst;
      q_vld <= d_vld;
    end
  end

endmodule

// File: rtl/regdst_track_pipe.sv
// Destination-register select plus DEPTH-stage in-flight tracker with RAW hazard flags.
// Optional macro REGDST_FWD_EN adds youngest-match forwarding index outputs.
module regdst_track_pipe
  import regdst_pkg::*;
#(
  parameter int REG_W    = REG_W_DEF,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = LINK_REG_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               dst_sel,
  input  logic [REG_W-1:0]         rt_in,
  input  logic [REG_W-1:0]         rd_in,
  input  logic                     wr_en_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [REG_W-1:0]         rs_chk,
  input  logic [REG_W-1:0]         rt_chk,
  output logic [REG_W-1:0]         dst_out,
  output logic [DEPTH*REG_W-1:0]   stage_dst,
  output logic [DEPTH-1:0]         stage_vld,
  output logic [REG_W-1:0]         wb_dst,
  output logic                     wb_vld,
`ifdef REGDST_FWD_EN
  output logic                     fwd_rs_hit,
  output logic [$clog2(DEPTH)-1:0] fwd_rs_idx,
  output logic                     fwd_rt_hit,
  output logic [$clog2(DEPTH)-1:0] fwd_rt_idx,
`endif
  output logic                     hazard_rs,
  output logic                     hazard_rt
);

  localparam logic [REG_W-1:0] LINK_IDX = REG_W'(LINK_REG);

  if (DEPTH < 2 || LINK_REG >= (2 ** REG_W)) begin : g_param_check
    $error("regdst_track_pipe: DEPTH must be >= 2 and LINK_REG must fit in REG_W bits");
  end

  logic             entry_vld;
  logic [REG_W-1:0] stg_dst [DEPTH];
  logic             stg_vld [DEPTH];

  always_comb begin
    case (dst_sel)
      DST_RD:   dst_out = rd_in;
      DST_LINK: dst_out = LINK_IDX;
      default:  dst_out = rt_in;
    endcase
  end

  // $zero is never a real destination, so it is never tracked.
  assign entry_vld = wr_en_in && (dst_out != '0);

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             ld;
    logic             bub;
    logic [REG_W-1:0] din;
    logic             vin;

    if (k == 0) begin : g_entry
      // Flush squashes the entering instruction even while stalled.
      assign ld  = !stall;
      assign bub = flush;
      assign din = dst_out;
      assign vin = entry_vld;
    end else if (k == 1) begin : g_ex
      // A stalled decode inserts a bubble behind itself so older work drains.
      assign ld  = 1'b1;
      assign bub = stall && !flush;
      assign din = stg_dst[0];
      assign vin = stg_vld[0];
    end else begin : g_tail
      assign ld  = 1'b1;
      assign bub = 1'b0;
      assign din = stg_dst[k-1];
      assign vin = stg_vld[k-1];
    end

    regdst_stage #(.REG_W(REG_W)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .load   (ld),
      .bubble (bub),
      .d_dst  (din),
      .d_vld  (vin),
      .q_dst  (stg_dst[k]),
      .q_vld  (stg_vld[k])
    );

    assign stage_dst[k*REG_W +: REG_W] = stg_dst[k];
    assign stage_vld[k]                = stg_vld[k];
  end

  assign wb_dst = stg_dst[DEPTH-1];
  assign wb_vld = stg_vld[DEPTH-1];

  always_comb begin
    hazard_rs = 1'b0;
    hazard_rt = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (stg_vld[k] && stg_dst[k] == rs_chk) hazard_rs = 1'b1;
      if (stg_vld[k] && stg_dst[k] == rt_chk) hazard_rt = 1'b1;
    end
    if (rs_chk == '0) hazard_rs = 1'b0;
    if (rt_chk == '0) hazard_rt = 1'b0;
  end

`ifdef REGDST_FWD_EN
  localparam int IDX_W = $clog2(DEPTH);

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    fwd_rs_hit = 1'b0;
    fwd_rs_idx = '0;
    fwd_rt_hit = 1'b0;
    fwd_rt_idx = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (stg_vld[k] && stg_dst[k] == rs_chk && rs_chk != '0) begin
        fwd_rs_hit = 1'b1;
        fwd_rs_idx = IDX_W'(k);
      end
      if (stg_vld[k] && stg_dst[k] == rt_chk && rt_chk != '0) begin
        fwd_rt_hit = 1'b1;
        fwd_rt_idx = IDX_W'(k);
      end
    end
    if (reset) begin
      fwd_rs_hit = 1'b0;
      fwd_rs_idx = '0;
      fwd_rt_hit = 1'b0;
      fwd_rt_idx = '0;
    end
  end
`endif

endmodule

// File: tb/tb_regdst_track_pipe.sv
// Scoreboard bench for regdst_track_pipe (DEPTH=3): directed vectors with hand-computed results.
module tb_regdst_track_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  dst_sel = 2'b00;
  logic [4:0]  rt_in = '0, rd_in = '0, rs_chk = '0, rt_chk = '0;
  logic        wr_en_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [4:0]  dst_out, wb_dst;
  logic [14:0] stage_dst;
  logic [2:0]  stage_vld;
  logic        wb_vld, hazard_rs, hazard_rt;
`ifdef REGDST_FWD_EN
  logic        fwd_rs_hit, fwd_rt_hit;
  logic [1:0]  fwd_rs_idx, fwd_rt_idx;
`endif

  regdst_track_pipe #(.REG_W(5), .DEPTH(3), .LINK_REG(31)) dut (
    .clk        (clk),
    .reset      (reset),
    .dst_sel    (dst_sel),
    .rt_in      (rt_in),
    .rd_in      (rd_in),
    .wr_en_in   (wr_en_in),
    .stall      (stall),
    .flush      (flush),
    .rs_chk     (rs_chk),
    .rt_chk     (rt_chk),
    .dst_out    (dst_out),
    .stage_dst  (stage_dst),
    .stage_vld  (stage_vld),
    .wb_dst     (wb_dst),
    .wb_vld     (wb_vld),
`ifdef REGDST_FWD_EN
    .fwd_rs_hit (fwd_rs_hit),
    .fwd_rs_idx (fwd_rs_idx),
    .fwd_rt_hit (fwd_rt_hit),
    .fwd_rt_idx (fwd_rt_idx),
`endif
    .hazard_rs  (hazard_rs),
    .hazard_rt  (hazard_rt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [4:0]  eout;
    logic [14:0] esd;
    logic [2:0]  ev;
    logic        ehs;
    logic        eht;
    logic [1:0]  ersi;
    logic [1:0]  erti;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   vid = 0;

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL v%0d %s: got %0h expected %0h", id, nm, act, req);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next rising edge.
  task automatic vec(input logic r, input logic [1:0] s, input logic [4:0] rt, input logic [4:0] rd,
                     input logic w, input logic st, input logic fl,
                     input logic [4:0] rsc, input logic [4:0] rtc,
                     input logic [4:0] eo, input logic [4:0] e0, input logic [4:0] e1, input logic [4:0] e2,
                     input logic [2:0] ev, input logic hs, input logic ht,
                     input logic [1:0] ri, input logic [1:0] ti);
    exp_t e;
    @(negedge clk);
    reset = r; dst_sel = s; rt_in = rt; rd_in = rd; wr_en_in = w;
    stall = st; flush = fl; rs_chk = rsc; rt_chk = rtc;
    vid++;
    e.id = vid; e.eout = eo; e.esd = {e2, e1, e0}; e.ev = ev;
    e.ehs = hs; e.eht = ht; e.ersi = ri; e.erti = ti;
    q.push_back(e);
    @(posedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk(e.id, "dst_out",   32'(dst_out),   32'(e.eout));
        chk(e.id, "stage_dst", 32'(stage_dst), 32'(e.esd));
        chk(e.id, "stage_vld", 32'(stage_vld), 32'(e.ev));
        chk(e.id, "wb_dst",    32'(wb_dst),    32'(e.esd[14:10]));
        chk(e.id, "wb_vld",    32'(wb_vld),    32'(e.ev[2]));
        chk(e.id, "hazard_rs", 32'(hazard_rs), 32'(e.ehs));
        chk(e.id, "hazard_rt", 32'(hazard_rt), 32'(e.eht));
`ifdef REGDST_FWD_EN
        chk(e.id, "fwd_rs_hit", 32'(fwd_rs_hit), 32'(e.ehs));
        chk(e.id, "fwd_rt_hit", 32'(fwd_rt_hit), 32'(e.eht));
        chk(e.id, "fwd_rs_idx", 32'(fwd_rs_idx), 32'(e.ersi));
        chk(e.id, "fwd_rt_idx", 32'(fwd_rt_idx), 32'(e.erti));
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    //   r  sel    rt     rd     w  st fl rs_c   rt_c   out    s0     s1     s2     vld    hs ht ri ti
    vec(1, 2'b01, 5'd0,  5'd8,  1, 1, 1, 5'd8,  5'd8,  5'd8,  5'd0,  5'd0,  5'd0,  3'b000, 0, 0, 0, 0);
    vec(1, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  3'b000, 0, 0, 0, 0);
    vec(0, 2'b01, 5'd0,  5'd8,  1, 0, 0, 5'd8,  5'd0,  5'd8,  5'd8,  5'd0,  5'd0,  3'b001, 1, 0, 0, 0);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd8,  5'd0,  5'd0,  5'd0,  5'd8,  5'd0,  3'b010, 1, 0, 1, 0);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd8,  5'd0,  5'd0,  5'd0,  5'd0,  5'd8,  3'b100, 1, 0, 2, 0);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd8,  5'd0,  5'd0,  5'd0,  5'd0,  5'd0,  3'b000, 0, 0, 0, 0);
    // link select, write to $zero, reserved select
    vec(0, 2'b10, 5'd3,  5'd4,  1, 0, 0, 5'd31, 5'd0,  5'd31, 5'd31, 5'd0,  5'd0,  3'b001, 1, 0, 0, 0);
    vec(0, 2'b00, 5'd0,  5'd0,  1, 0, 0, 5'd0,  5'd0,  5'd0,  5'd0,  5'd31, 5'd0,  3'b010, 0, 0, 0, 0);
    vec(0, 2'b11, 5'd6,  5'd2,  1, 0, 0, 5'd6,  5'd31, 5'd6,  5'd6,  5'd0,  5'd31, 3'b101, 1, 1, 0, 2);
    vec(0, 2'b01, 5'd1,  5'd9,  1, 0, 0, 5'd9,  5'd6,  5'd9,  5'd9,  5'd6,  5'd0,  3'b011, 1, 1, 0, 1);
    // rd=5 enters, then two stall cycles: 5 holds, bubbles behind it, 9 drains
    vec(0, 2'b01, 5'd1,  5'd5,  1, 0, 0, 5'd5,  5'd31, 5'd5,  5'd5,  5'd9,  5'd6,  3'b111, 1, 0, 0, 0);
    vec(0, 2'b01, 5'd1,  5'd13, 1, 1, 0, 5'd13, 5'd9,  5'd13, 5'd5,  5'd0,  5'd9,  3'b101, 0, 1, 0, 2);
    vec(0, 2'b01, 5'd1,  5'd13, 1, 1, 0, 5'd13, 5'd5,  5'd13, 5'd5,  5'd0,  5'd0,  3'b001, 0, 1, 0, 0);
    vec(0, 2'b01, 5'd1,  5'd13, 1, 0, 0, 5'd13, 5'd5,  5'd13, 5'd13, 5'd5,  5'd0,  3'b011, 1, 1, 0, 1);
    // flush with and without stall
    vec(0, 2'b01, 5'd1,  5'd12, 1, 1, 1, 5'd12, 5'd13, 5'd12, 5'd0,  5'd13, 5'd5,  3'b110, 0, 1, 0, 1);
    vec(0, 2'b01, 5'd1,  5'd14, 1, 0, 1, 5'd14, 5'd5,  5'd14, 5'd0,  5'd0,  5'd13, 3'b100, 0, 0, 0, 0);
    // fill, then reset mid-stream with stall/flush asserted
    vec(0, 2'b01, 5'd1,  5'd20, 1, 0, 0, 5'd13, 5'd20, 5'd20, 5'd20, 5'd0,  5'd0,  3'b001, 0, 1, 0, 0);
    vec(0, 2'b01, 5'd1,  5'd21, 1, 0, 0, 5'd20, 5'd21, 5'd21, 5'd21, 5'd20, 5'd0,  3'b011, 1, 1, 1, 0);
    vec(0, 2'b01, 5'd1,  5'd22, 1, 0, 0, 5'd20, 5'd22, 5'd22, 5'd22, 5'd21, 5'd20, 3'b111, 1, 1, 2, 0);
    vec(1, 2'b01, 5'd1,  5'd23, 1, 1, 1, 5'd20, 5'd22, 5'd23, 5'd0,  5'd0,  5'd0,  3'b000, 0, 0, 0, 0);
    // untracked write keeps its dst but never flags
    vec(0, 2'b01, 5'd1,  5'd24, 0, 0, 0, 5'd24, 5'd24, 5'd24, 5'd24, 5'd0,  5'd0,  3'b000, 0, 0, 0, 0);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd24, 5'd0,  5'd0,  5'd0,  5'd24, 5'd0,  3'b000, 0, 0, 0, 0);
    // rd=7 in stages 0 and 2: youngest match wins, then ages by one
    vec(0, 2'b01, 5'd1,  5'd7,  1, 0, 0, 5'd0,  5'd0,  5'd7,  5'd7,  5'd0,  5'd24, 3'b001, 0, 0, 0, 0);
    vec(0, 2'b01, 5'd1,  5'd8,  1, 0, 0, 5'd0,  5'd0,  5'd8,  5'd8,  5'd7,  5'd0,  3'b011, 0, 0, 0, 0);
    vec(0, 2'b01, 5'd1,  5'd7,  1, 0, 0, 5'd7,  5'd8,  5'd7,  5'd7,  5'd8,  5'd7,  3'b111, 1, 1, 0, 1);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd7,  5'd8,  5'd0,  5'd0,  5'd7,  5'd8,  3'b110, 1, 1, 1, 2);
    vec(0, 2'b00, 5'd0,  5'd0,  0, 0, 0, 5'd7,  5'd8,  5'd0,  5'd0,  5'd0,  5'd7,  3'b100, 1, 0, 2, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
